data_ram_responder: RTL and testbench
=====================================

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; the internal array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 3, number of stall cycles per non-posted access; legal range 2..16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ram_cs  input  1  data-RAM chip select from the core.
REQ-006 mem_ren  input  1  read request.
REQ-007 mem_wen  input  1  write request.
REQ-008 mem_addr  input  32  byte address.
REQ-009 mem_dout  input  32  write data from the core.
REQ-010 mem_din  output  32  read data to the core, registered.
REQ-011 ram_stall  output  1  holds the core pipeline while an access is outstanding.

Function
REQ-012 A request is ram_cs=1 and (mem_ren=1 or mem_wen=1); mem_wen=1 with mem_ren=1 is treated as a write.
REQ-013 Word index = mem_addr[ADDR_WIDTH+1:2]; mem_addr[1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses wrap.
REQ-014 FSM states IDLE, BUSY, DONE; the 4-bit down-counter cnt is meaningful only in BUSY.
REQ-015 IDLE: on a request, ram_stall=1 combinationally in that same cycle; on the clock edge, latch op/index/write data, load cnt=LATENCY-2, go to BUSY; with no request, stay in IDLE with ram_stall=0.
REQ-016 BUSY: ram_stall=1; if cnt!=0, decrement; if cnt==0, perform the access on the edge (write the array, or load mem_din from the array) and go to DONE.
REQ-017 DONE: ram_stall=0 for exactly one cycle, so the core captures mem_din; always return to IDLE; the still-visible request in DONE is not re-accepted.
REQ-018 Non-posted latency: request presented in cycle 0; ram_stall high in cycles 0..LATENCY-1; low in cycle LATENCY, with read data valid on mem_din.
REQ-019 If ram_cs falls while in BUSY, the access aborts: no array write, mem_din unchanged, next state IDLE, and ram_stall=0 in that cycle.
REQ-020 mem_din holds the last completed read value; writes and aborts never modify it.
REQ-021 Back-to-back requests: a new request is accepted no earlier than the cycle after DONE; throughput is one access per LATENCY+1 cycles.

Reset
REQ-022 rst=1 forces state IDLE, cnt=0, mem_din=32'h0, ram_stall=0 and clears the latched request, immediately and asynchronously.
REQ-023 rst asserted mid-access aborts that access; no array write occurs. Array contents are not cleared by reset.

Configuration
REQ-024 Macro RESP_POSTED_WRITE_EN. When defined, a write request in IDLE keeps ram_stall=0, commits to the array on that clock edge, and the FSM stays in IDLE. Reads are unchanged.
REQ-025 When RESP_POSTED_WRITE_EN is undefined, writes follow REQ-015..REQ-018 exactly like reads.

Verification
REQ-026 Reset: assert rst mid-BUSY -> ram_stall=0 and mem_din=0 immediately; a subsequent read of that address returns its pre-access value.
REQ-027 LATENCY=3, write 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ram_stall high for 3 cycles on each access; mem_din=32'hDEADBEEF in the read's DONE cycle.
REQ-028 ADDR_WIDTH=10: write 32'h12345678 to 0x0000_1004, read 0x0000_0007 -> returns 32'h12345678 (wrap and low-bit masking).
REQ-029 Read issued, ram_cs dropped during the second BUSY cycle -> ram_stall=0 that cycle, mem_din unchanged, FSM back in IDLE, no DONE pulse.
REQ-030 mem_ren=1 and mem_wen=1 with data 32'hA5A5A5A5 at 0x20 -> array written with 32'hA5A5A5A5; mem_din unchanged.
REQ-031 RESP_POSTED_WRITE_EN defined: write to 0x40 followed by a read of 0x40 in the next cycle -> zero stall cycles on the write; read returns the new data after LATENCY stall cycles.

Source files
------------

// File: rtl/data_ram_responder_if.sv
// Core <-> data-RAM responder handshake: request strobes, byte address, data both ways and the stall back to the core.
interface data_ram_responder_if;
  logic        ram_cs;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        ram_stall;

  modport master (
    output ram_cs, mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, ram_stall
  );

  modport slave (
    input  ram_cs, mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, ram_stall
  );
endinterface

// File: rtl/data_ram_responder.sv
// Word-addressed data RAM answering core accesses after LATENCY stall cycles; stall is held until data is ready, dropping ram_cs aborts.
// Optional RESP_POSTED_WRITE_EN: writes commit in IDLE with no stall, reads keep the full latency.
module data_ram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input logic                 clk,
  input logic                 rst,
  data_ram_responder_if.slave bus
);

`ifdef RESP_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [31:0]             wdata;
  logic [31:0]             din_q;
  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];

  logic                    req;
  logic                    posted_wr;
  logic [ADDR_WIDTH-1:0]   addr_idx;
  logic                    stall;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [31:0]             wdat;
  logic                    unused_addr_bits;

  assign addr_idx         = bus.mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_WIDTH+2], bus.mem_addr[1:0]};
  assign req              = bus.ram_cs & (bus.mem_ren | bus.mem_wen);
  assign posted_wr        = POSTED & bus.mem_wen;

  // Stall and the array write strobe are combinational so a request stalls in its own cycle
  // and reset or a dropped chip select releases the core immediately.
  always_comb begin
    stall = 1'b0;
    we    = 1'b0;
    waddr = idx;
    wdat  = wdata;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req && posted_wr) begin
            we    = 1'b1;
            waddr = addr_idx;
            wdat  = bus.mem_dout;
          end else if (req) begin
            stall = 1'b1;
          end
        end
        BUSY: begin
          if (bus.ram_cs) begin
            stall = 1'b1;
            we    = op_write && (cnt == 4'd0);
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents survive reset, so it lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      idx      <= '0;
      wdata    <= 32'h0;
      din_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !posted_wr) begin
            op_write <= bus.mem_wen;
            idx      <= addr_idx;
            wdata    <= bus.mem_dout;
            cnt      <= 4'(LATENCY - 2);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.ram_cs) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_write) din_q <= mem[idx];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_stall = stall;
  assign bus.mem_din   = din_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized bench for data_ram_responder against a word-array reference model.
module tb_data_ram_responder;
  localparam int AW  = 10;
  localparam int LAT = 3;
`ifdef RESP_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk;
  logic rst;
  data_ram_responder_if bus ();

  data_ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model [0:(1<<AW)-1];
  logic [31:0] last_read;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic set_idle();
    bus.ram_cs   = 1'b0;
    bus.mem_ren  = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.mem_addr = 32'h0;
    bus.mem_dout = 32'h0;
  endtask

  // Called just after a rising edge; returns just after the rising edge that ends the
  // zero-stall cycle, so consecutive calls are back-to-back.
  task automatic access(input bit ren, input bit wen, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int  stalls;
    bit  is_wr;
    bit  done;
    int  exp_stalls;
    is_wr        = wen;
    bus.ram_cs   = 1'b1;
    bus.mem_ren  = ren;
    bus.mem_wen  = wen;
    bus.mem_addr = addr;
    bus.mem_dout = data;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.ram_stall) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'(stalls), 32'(LAT));
    end else begin
      exp_stalls = (is_wr && POSTED) ? 0 : LAT;
      check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      if (is_wr) begin
        model[widx(addr)] = data;
      end else begin
        last_read = model[widx(addr)];
      end
      check({tag, "_din"}, bus.mem_din, last_read);
    end
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // Read or write dropped on the second BUSY cycle: must release at once and leave no trace.
  task automatic abort_access(input bit wen, input logic [31:0] addr, input logic [31:0] data);
    bus.ram_cs   = 1'b1;
    bus.mem_ren  = !wen;
    bus.mem_wen  = wen;
    bus.mem_addr = addr;
    bus.mem_dout = data;
    @(negedge clk);
    check("abort_c0_stall", 32'(bus.ram_stall), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.ram_cs = 1'b0;
    #1;
    check("abort_drop_stall", 32'(bus.ram_stall), 32'd0);
    @(negedge clk);
    check("abort_din", bus.mem_din, last_read);
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    check("abort_idle_stall", 32'(bus.ram_stall), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          k;
    set_idle();
    last_read = 32'h0;
    rst = 1'b1;
    bus.ram_cs  = 1'b1;
    bus.mem_ren = 1'b1;
    #3;
    check("reset_stall", 32'(bus.ram_stall), 32'd0);
    check("reset_din", bus.mem_din, 32'h0);
    set_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Seed a pool of 32 words so every later read has a known value.
    for (int i = 0; i < 32; i++) begin
      access(1'b0, 1'b1, 32'(i) << 2, $urandom, "init_wr");
    end

    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, "beef_wr");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, "beef_rd");
    check("beef_value", bus.mem_din, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h0000_1004, 32'h12345678, "wrap_wr");
    access(1'b1, 1'b0, 32'h0000_0007, 32'h0, "wrap_rd");
    check("wrap_value", bus.mem_din, 32'h12345678);

    access(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5A5A5, "rw_both");
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, "rw_both_rd");
    check("rw_both_value", bus.mem_din, 32'hA5A5A5A5);

    access(1'b0, 1'b1, 32'h0000_0040, 32'hC0FFEE01, "b2b_wr");
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, "b2b_rd");
    check("b2b_value", bus.mem_din, 32'hC0FFEE01);

    abort_access(1'b0, 32'h0000_0044, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, "post_abort_rd");
    if (!POSTED) begin
      abort_access(1'b1, 32'h0000_0048, 32'h0BAD0BAD);
      access(1'b1, 1'b0, 32'h0000_0048, 32'h0, "post_abort_wr_rd");
    end

    // Reset in the middle of BUSY.
    bus.ram_cs   = 1'b1;
    bus.mem_wen  = 1'b1;
    bus.mem_addr = 32'h0000_0014;
    bus.mem_dout = 32'h5EED5EED;
    if (POSTED) model[5] = 32'h5EED5EED;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(bus.ram_stall), 32'd0);
    check("midrst_din", bus.mem_din, 32'h0);
    set_idle();
    last_read = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, "midrst_rd");

    for (int n = 0; n < 150; n++) begin
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
      d = $urandom;
      k = $urandom_range(0, 9);
      if (k < 4)       access(1'b1, 1'b0, a, d, "rnd_rd");
      else if (k < 7)  access(1'b0, 1'b1, a, d, "rnd_wr");
      else if (k < 9)  access(1'b1, 1'b1, a, d, "rnd_rw");
      else             abort_access(POSTED ? 1'b0 : 1'($urandom_range(0, 1)), a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
